// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-port word memory behind a simple req/ready handshake. A request is
//   accepted in IDLE, waits LATENCY wait-state cycles in BUSY, then completes
//   with a one-cycle ready pulse in DONE. Reads load readdata on entry to DONE;
//   writes update storage on the edge that leaves DONE.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, 4..1024)
//   LATENCY  wait-state cycles before the response (0..7)
//
// Ports
//   clk_i        clock, rising-edge active
//   reset_i      asynchronous active-high reset
//   req_i        request strobe, sampled in IDLE
//   memwrite_i   1 = write, 0 = read (captured at acceptance)
//   dataadr_i    byte address (captured at acceptance)
//   writedata_i  store data (captured at acceptance)
//   readdata_o   registered load data, held until the next read completes
//   ready_o      one-cycle completion pulse
//   err_o        misalignment flag (only with MEM_MISALIGN_ERR_EN)
//
// Optional feature macro: MEM_MISALIGN_ERR_EN
//   When defined, a transaction whose address has nonzero bits [1:0] still
//   runs its full latency but raises err_o with ready_o, suppresses the write
//   and leaves readdata unchanged. When undefined, bits [1:0] are ignored.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        memwrite_i,
    input  logic [31:0] dataadr_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] readdata_o,
    output logic        ready_o
`ifdef MEM_MISALIGN_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    // Counter load value; BUSY exits on the edge where the counter is zero,
    // so LATENCY-1 gives exactly LATENCY BUSY cycles.
    localparam logic [2:0] LOAD_C = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            mis_q, mis_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            ready_q, ready_d;
    logic [31:0]     mem_q [DEPTH];
`ifdef MEM_MISALIGN_ERR_EN
    logic            err_q, err_d;
    logic            unused_s;
    assign unused_s = ^dataadr_i[31:AW+2];
`else
    logic            unused_s;
    assign unused_s = ^{dataadr_i[31:AW+2], dataadr_i[1:0]};
`endif

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        mis_d      = mis_q;
        readdata_d = readdata_q;
        ready_d    = 1'b0;
`ifdef MEM_MISALIGN_ERR_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = memwrite_i;
                    idx_d   = dataadr_i[AW+1:2];
                    wdata_d = writedata_i;
`ifdef MEM_MISALIGN_ERR_EN
                    mis_d   = (dataadr_i[1:0] != 2'b00);
`else
                    mis_d   = 1'b0;
`endif
                    if (LATENCY == 0) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LOAD_C;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        // The _d capture values are used here so a zero-latency transaction,
        // which enters DONE on its accepting edge, sees the live inputs.
        if (state_d == DONE) begin
            ready_d = 1'b1;
`ifdef MEM_MISALIGN_ERR_EN
            err_d   = mis_d;
`endif
            if (!we_d && !mis_d) begin
                readdata_d = mem_q[idx_d];
            end else begin
                readdata_d = readdata_q;
            end
        end else begin
            ready_d = 1'b0;
        end
    end

    // State, capture and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            mis_q      <= 1'b0;
            readdata_q <= 32'd0;
            ready_q    <= 1'b0;
`ifdef MEM_MISALIGN_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            mis_q      <= mis_d;
            readdata_q <= readdata_d;
            ready_q    <= ready_d;
`ifdef MEM_MISALIGN_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // Storage write on the edge leaving DONE; storage is never reset, and a
    // reset during DONE forces IDLE first so the write cannot happen.
    always_ff @(posedge clk_i) begin
        if (state_q == DONE && we_q && !mis_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign readdata_o = readdata_q;
    assign ready_o    = ready_q;
`ifdef MEM_MISALIGN_ERR_EN
    assign err_o      = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder (DEPTH=64, LATENCY=2). A reference
//   model holds the memory as a plain word array indexed by (addr/4) mod DEPTH
//   and predicts ready timing as LATENCY+1 cycles after acceptance.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
`ifdef MEM_MISALIGN_ERR_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_vld [DEPTH];
    logic [31:0] exp_rd;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req),
        .memwrite_i  (memwrite),
        .dataadr_i   (dataadr),
        .writedata_i (writedata),
        .readdata_o  (readdata),
        .ready_o     (ready)
`ifdef MEM_MISALIGN_ERR_EN
        ,
        .err_o       (err)
`endif
    );

    always #5 clk = ~clk;

    // Compare one observed value against the expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction, called at a negedge while the DUT is idle. Returns at
    // the negedge of the idle cycle after completion, so calls chain at the
    // minimum transaction period.
    task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                       input bit scramble, input bit exp_err);
        int unsigned widx;
        widx = (adr / 32'd4) % DEPTH;
        memwrite  = we;
        dataadr   = adr;
        writedata = wd;
        req       = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (scramble && k == 1) begin
                req       = 1'b0;
                memwrite  = $urandom_range(0, 1);
                dataadr   = $urandom;
                writedata = $urandom;
            end
            if (k <= LAT) begin
                check("ready_wait", {31'd0, ready}, 32'd0);
            end else begin
                check("ready_pulse", {31'd0, ready}, 32'd1);
                if (!we && !exp_err) begin
                    exp_rd = model_mem[widx];
                end
                check(we ? "rdata_hold_wr" : "rdata_read", readdata, exp_rd);
`ifdef MEM_MISALIGN_ERR_EN
                check("err_flag", {31'd0, err}, {31'd0, exp_err});
`endif
                req = 1'b0;
            end
        end
        if (we && !exp_err) begin
            model_mem[widx] = wd;
            model_vld[widx] = 1'b1;
        end
        @(negedge clk);
        check("ready_single", {31'd0, ready}, 32'd0);
        check("rdata_hold", readdata, exp_rd);
    endtask

    initial begin
        logic [31:0] adr;
        bit          we;
        bit          mis;
        int unsigned word;

        for (int i = 0; i < DEPTH; i++) begin
            model_vld[i] = 1'b0;
            model_mem[i] = 32'd0;
        end
        exp_rd    = 32'd0;
        reset     = 1'b1;
        req       = 1'b0;
        memwrite  = 1'b0;
        dataadr   = 32'd0;
        writedata = 32'd0;

        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rdata", readdata, 32'd0);
`ifdef MEM_MISALIGN_ERR_EN
        check("reset_err", {31'd0, err}, 32'd0);
`endif
        reset = 1'b0;

        // First acceptance on the first edge after reset release.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

        // Aliasing modulo 4*DEPTH bytes.
        txn(1'b1, 32'h000, 32'h55, 1'b0, 1'b0);
        txn(1'b0, 32'h100, 32'h0, 1'b0, 1'b0);

        // Inputs changed and req dropped mid-BUSY are ignored.
        txn(1'b1, 32'h4, 32'h11111111, 1'b0, 1'b0);
        txn(1'b1, 32'h8, 32'h22222222, 1'b0, 1'b0);
        txn(1'b0, 32'h4, 32'h0, 1'b1, 1'b0);

        // Reset one cycle after accepting a write aborts it.
        txn(1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
        memwrite  = 1'b1;
        dataadr   = 32'h20;
        writedata = 32'hA5A5A5A5;
        req       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_rdata", readdata, 32'd0);
        exp_rd = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            check("abort_no_pulse", {31'd0, ready}, 32'd0);
        end
        txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

`ifdef MEM_MISALIGN_ERR_EN
        // Misaligned write: flagged, suppressed.
        txn(1'b1, 32'h22, 32'h77, 1'b0, 1'b1);
        txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            word = $urandom_range(0, DEPTH - 1);
            we   = $urandom_range(0, 1) == 1;
            if (!model_vld[word]) begin
                we = 1'b1;
            end
            adr = (($urandom_range(0, 3) * DEPTH) + word) * 4;
            mis = 1'b0;
`ifdef MEM_MISALIGN_ERR_EN
            if ($urandom_range(0, 7) == 0) begin
                adr[1:0] = 2'($urandom_range(1, 3));
                mis      = 1'b1;
            end
`else
            adr[1:0] = 2'($urandom_range(0, 3));
`endif
            txn(we, adr, $urandom, $urandom_range(0, 1) == 1, mis);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
